// File: rtl/soc_system_gpio_pkg.sv
// Register offsets and edge-capture encodings shared by the GPIO/IRQ block.
// Pure definitions: no latency, no backpressure.
package soc_system_gpio_pkg;

  localparam logic [2:0] REG_DATA    = 3'd0;
  localparam logic [2:0] REG_OUT     = 3'd1;
  localparam logic [2:0] REG_IRQMASK = 3'd2;
  localparam logic [2:0] REG_EDGECAP = 3'd3;
  localparam logic [2:0] REG_OUTSET  = 3'd4;
  localparam logic [2:0] REG_OUTCLR  = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/soc_system_gpio_sync.sv
// Input synchroniser, previous-sample register and armed edge detector.
// sync lags in_port by SYNC_STAGES clocks, det is combinational from sync/prev; no backpressure.
module soc_system_gpio_sync
  import soc_system_gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] det
);

  localparam int              ARM_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] chain [SYNC_STAGES];
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edges;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      prev    <= '0;
      arm_cnt <= '0;
    end else begin
      chain[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      prev <= sync;
      if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);
    end
  end

  assign sync  = chain[SYNC_STAGES-1];
  assign armed = (arm_cnt == ARM_MAX);

  always_comb begin
    edges = sync & ~prev;
    if (EDGE_TYPE == EDGE_FALLING) edges = ~sync & prev;
    else if (EDGE_TYPE == EDGE_ANY) edges = sync ^ prev;
  end

  // Until the chain and prev have refilled after reset, sync vs prev is meaningless.
  assign det = armed ? edges : '0;

endmodule

// File: rtl/soc_system_gpio_irq.sv
// Avalon-MM PIO: output register with set/clear, synchronised inputs, edge capture, masked irq.
// Writes take effect on the write edge, readdata and irq are registered (1 cycle); never stalls.
module soc_system_gpio_irq
  import soc_system_gpio_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_RISING,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic             unused_wd;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] cap_next;
  logic [WIDTH-1:0] rd_word;
  logic [31:0]      rd_next;

  soc_system_gpio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .in_port(in_port),
    .sync   (sync),
    .det    (det)
  );

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  // Detection wins over a same-cycle clear so no edge is ever lost.
  always_comb begin
    cap_clr  = (wr && address == REG_EDGECAP) ? wd : '0;
    cap_next = (edge_cap & ~cap_clr) | det;
  end

  always_comb begin
    rd_word = '0;
    case (address)
      REG_DATA:    rd_word = sync;
      REG_OUT:     rd_word = out_reg;
      REG_IRQMASK: rd_word = irq_mask;
      REG_EDGECAP: rd_word = edge_cap;
      default:     rd_word = '0;
    endcase
    rd_next = '0;
    rd_next[WIDTH-1:0] = rd_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg  <= OUT_RESET;
      irq_mask <= '0;
      edge_cap <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      if (wr) begin
        case (address)
          REG_DATA, REG_OUT: out_reg  <= wd;
          REG_IRQMASK:       irq_mask <= wd;
          REG_OUTSET:        out_reg  <= out_reg | wd;
          REG_OUTCLR:        out_reg  <= out_reg & ~wd;
          default: ;
        endcase
      end
      edge_cap <= cap_next;
      irq      <= |(edge_cap & irq_mask);
      readdata <= rd_next;
    end
  end

  assign out_port = out_reg;

endmodule

// File: tb/tb_soc_system_gpio_irq.sv
// Scenario bench for soc_system_gpio_irq: expectations queued at stimulus time, popped at observation.
module tb_soc_system_gpio_irq;

  localparam int          WIDTH       = 32;
  localparam int          SYNC_STAGES = 2;
  localparam int          EDGE_TYPE   = 0;
  localparam logic [31:0] OUT_RESET   = 32'hA5;

  localparam logic [2:0] A_DATA = 3'd0, A_OUT = 3'd1, A_MASK = 3'd2, A_CAP = 3'd3;
  localparam logic [2:0] A_SET  = 3'd4, A_CLR = 3'd5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] in_port = '1;
  logic [WIDTH-1:0] out_port;
  logic             irq;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q [$];

  soc_system_gpio_irq #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE),
    .OUT_RESET  (OUT_RESET)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .out_port  (out_port),
    .irq       (irq)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1);
  end

  // Called at a negedge; the write lands on the following posedge, returns at the next negedge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] e, got;
    repeat (3) @(negedge clk);
    exp_q.push_back(OUT_RESET); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); tests_run++;
    if (out_port !== e) begin tests_failed++; $display("FAIL reset_out: got %h expected %h", out_port, e); end
    e = exp_q.pop_front(); tests_run++;
    if ({31'b0, irq} !== e) begin tests_failed++; $display("FAIL reset_irq: got %b expected %h", irq, e); end
    e = exp_q.pop_front(); tests_run++;
    if (readdata !== e) begin tests_failed++; $display("FAIL reset_readdata: got %h expected %h", readdata, e); end

    reset = 1'b0;
    address = A_CAP;
    repeat (10) @(negedge clk);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'hFFFF_FFFF);
    e = exp_q.pop_front(); tests_run++;
    if (readdata !== e) begin tests_failed++; $display("FAIL arm_no_spurious_cap: got %h expected %h", readdata, e); end
    e = exp_q.pop_front(); tests_run++;
    if ({31'b0, irq} !== e) begin tests_failed++; $display("FAIL arm_irq: got %b expected %h", irq, e); end
    bus_read(A_DATA, got);
    e = exp_q.pop_front(); tests_run++;
    if (got !== e) begin tests_failed++; $display("FAIL data_read_sync: got %h expected %h", got, e); end
  endtask

  task automatic test_out_set_clr();
    logic [2:0]  wa [7];
    logic [31:0] wdv [7];
    logic [2:0]  ra [6];
    logic [31:0] e, got;
    wa[0] = A_OUT;  wdv[0] = 32'h0000_00F0; exp_q.push_back(32'hF0);
    wa[1] = A_SET;  wdv[1] = 32'h0000_000F; exp_q.push_back(32'hFF);
    wa[2] = A_CLR;  wdv[2] = 32'h0000_0030; exp_q.push_back(32'hCF);
    wa[3] = 3'd6;   wdv[3] = 32'hFFFF_FFFF; exp_q.push_back(32'hCF);
    wa[4] = A_DATA; wdv[4] = 32'h0000_1234; exp_q.push_back(32'h1234);
    wa[5] = 3'd7;   wdv[5] = 32'h0000_0000; exp_q.push_back(32'h1234);
    wa[6] = A_OUT;  wdv[6] = 32'h0000_00CF; exp_q.push_back(32'hCF);
    for (int i = 0; i < 7; i++) begin
      bus_write(wa[i], wdv[i]);
      e = exp_q.pop_front(); tests_run++;
      if (out_port !== e) begin
        tests_failed++; $display("FAIL out_write[%0d]: got %h expected %h", i, out_port, e);
      end
    end
    ra[0] = A_SET; ra[1] = A_CLR; ra[2] = 3'd6; ra[3] = 3'd7; ra[4] = A_OUT; ra[5] = A_MASK;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'hCF); exp_q.push_back(32'h0);
    for (int i = 0; i < 6; i++) begin
      bus_read(ra[i], got);
      e = exp_q.pop_front(); tests_run++;
      if (got !== e) begin
        tests_failed++; $display("FAIL read_offset_%0d: got %h expected %h", ra[i], got, e);
      end
    end
  endtask

  task automatic test_rise_capture();
    logic [31:0] e;
    in_port = '0;
    bus_write(A_CAP, 32'hFFFF_FFFF);
    bus_write(A_MASK, 32'h1);
    repeat (4) @(negedge clk);
    address = A_CAP;
    in_port[0] = 1'b1;
    // irq and readdata(EDGECAP) after edges k..k+3
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back((c == 3) ? 32'h1 : 32'h0);
      exp_q.push_back((c == 3) ? 32'h1 : 32'h0);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = exp_q.pop_front(); tests_run++;
      if ({31'b0, irq} !== e) begin tests_failed++; $display("FAIL rise_irq_k+%0d: got %b expected %h", c, irq, e); end
      e = exp_q.pop_front(); tests_run++;
      if (readdata !== e) begin tests_failed++; $display("FAIL rise_cap_k+%0d: got %h expected %h", c, readdata, e); end
    end
    in_port[0] = 1'b0;
    exp_q.push_back(32'h1); exp_q.push_back(32'h1);
    repeat (5) @(negedge clk);
    e = exp_q.pop_front(); tests_run++;
    if (readdata !== e) begin tests_failed++; $display("FAIL fall_ignored_cap: got %h expected %h", readdata, e); end
    e = exp_q.pop_front(); tests_run++;
    if ({31'b0, irq} !== e) begin tests_failed++; $display("FAIL fall_ignored_irq: got %b expected %h", irq, e); end
  endtask

  task automatic test_clear_collision();
    logic [31:0] e;
    in_port[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    // this clear lands on the same edge the new rising edge is captured
    bus_write(A_CAP, 32'h1);
    exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'h1);
    e = exp_q.pop_front(); tests_run++;
    if ({31'b0, irq} !== e) begin tests_failed++; $display("FAIL collide_irq_w: got %b expected %h", irq, e); end
    @(negedge clk);
    e = exp_q.pop_front(); tests_run++;
    if ({31'b0, irq} !== e) begin tests_failed++; $display("FAIL collide_irq_w+1: got %b expected %h", irq, e); end
    e = exp_q.pop_front(); tests_run++;
    if (readdata !== e) begin tests_failed++; $display("FAIL collide_cap: got %h expected %h", readdata, e); end

    repeat (2) @(negedge clk);
    bus_write(A_CAP, 32'h1);
    exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); tests_run++;
    if ({31'b0, irq} !== e) begin tests_failed++; $display("FAIL quiet_clear_irq_w: got %b expected %h", irq, e); end
    @(negedge clk);
    e = exp_q.pop_front(); tests_run++;
    if ({31'b0, irq} !== e) begin tests_failed++; $display("FAIL quiet_clear_irq_w+1: got %b expected %h", irq, e); end
    e = exp_q.pop_front(); tests_run++;
    if (readdata !== e) begin tests_failed++; $display("FAIL quiet_clear_cap: got %h expected %h", readdata, e); end
  endtask

  task automatic test_mask_unmask();
    logic [31:0] e;
    bus_write(A_MASK, 32'h0);
    address = A_CAP;
    in_port[3] = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h8);
    repeat (6) @(negedge clk);
    e = exp_q.pop_front(); tests_run++;
    if ({31'b0, irq} !== e) begin tests_failed++; $display("FAIL masked_irq: got %b expected %h", irq, e); end
    e = exp_q.pop_front(); tests_run++;
    if (readdata !== e) begin tests_failed++; $display("FAIL masked_cap: got %h expected %h", readdata, e); end

    bus_write(A_MASK, 32'h8);
    exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h8);
    e = exp_q.pop_front(); tests_run++;
    if ({31'b0, irq} !== e) begin tests_failed++; $display("FAIL unmask_irq_w: got %b expected %h", irq, e); end
    @(negedge clk);
    e = exp_q.pop_front(); tests_run++;
    if ({31'b0, irq} !== e) begin tests_failed++; $display("FAIL unmask_irq_w+1: got %b expected %h", irq, e); end
    e = exp_q.pop_front(); tests_run++;
    if (readdata !== e) begin tests_failed++; $display("FAIL unmask_mask_read: got %h expected %h", readdata, e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e, got;
    exp_q.push_back(32'h1);
    e = exp_q.pop_front(); tests_run++;
    if ({31'b0, irq} !== e) begin tests_failed++; $display("FAIL pre_reset_irq: got %b expected %h", irq, e); end

    #2 reset = 1'b1;
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(OUT_RESET); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); tests_run++;
    if ({31'b0, irq} !== e) begin tests_failed++; $display("FAIL async_reset_irq: got %b expected %h", irq, e); end
    e = exp_q.pop_front(); tests_run++;
    if (out_port !== e) begin tests_failed++; $display("FAIL async_reset_out: got %h expected %h", out_port, e); end
    e = exp_q.pop_front(); tests_run++;
    if (readdata !== e) begin tests_failed++; $display("FAIL async_reset_readdata: got %h expected %h", readdata, e); end

    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_port[5] = ~in_port[5];
    end
    @(negedge clk);
    in_port = 32'h0000_0029;
    address = A_CAP;
    reset = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    repeat (10) @(negedge clk);
    e = exp_q.pop_front(); tests_run++;
    if (readdata !== e) begin tests_failed++; $display("FAIL rearm_no_spurious_cap: got %h expected %h", readdata, e); end
    e = exp_q.pop_front(); tests_run++;
    if ({31'b0, irq} !== e) begin tests_failed++; $display("FAIL rearm_irq: got %b expected %h", irq, e); end
    bus_read(A_MASK, got);
    e = exp_q.pop_front(); tests_run++;
    if (got !== e) begin tests_failed++; $display("FAIL rearm_mask_cleared: got %h expected %h", got, e); end

    in_port[6] = 1'b1;
    exp_q.push_back(32'h40);
    repeat (5) @(negedge clk);
    bus_read(A_CAP, got);
    e = exp_q.pop_front(); tests_run++;
    if (got !== e) begin tests_failed++; $display("FAIL rearmed_capture: got %h expected %h", got, e); end
  endtask

  initial begin
    test_reset();
    test_out_set_clr();
    test_rise_capture();
    test_clear_collision();
    test_mask_unmask();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
